// File: rtl/oclib_pkg.sv
// Shared types for the oclib reset sequencer.
package oclib_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    DONE
  } oclib_reset_seq_state_e;

endpackage

// File: rtl/oclib_reset_release_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after Depth clock edges.
module oclib_reset_release_sync #(
  parameter int unsigned Depth = 3
) (
  input  logic clock,
  input  logic resetN,
  output logic synced
);

  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [Depth-1:0] sync_q;

  // Shift ones in once reset is released; any low on resetN clears the chain.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Depth-2:0], 1'b1};
    end
  end

  assign synced = sync_q[Depth-1];

endmodule

// File: rtl/oclib_reset_sequencer.sv
// Multi-channel reset sequencer: common assert, staggered release, min assert width.
module oclib_reset_sequencer #(
  parameter int unsigned Channels        = 4,
  parameter int unsigned SyncCycles      = 3,
  parameter int unsigned MinAssertCycles = 16,
  parameter int unsigned ReleaseGap      = 8,
  parameter int unsigned ResetPipeline   = 0
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                softReset,
  output logic [Channels-1:0] out,
  output logic                ready,
  output logic                busy
);

  import oclib_pkg::*;

  localparam int unsigned CntMax = (MinAssertCycles > ReleaseGap) ? MinAssertCycles : ReleaseGap;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(Channels + 1);
  localparam int unsigned MinM1  = MinAssertCycles - 1;
  localparam int unsigned GapM1  = (ReleaseGap > 0) ? ReleaseGap - 1 : 0;
  localparam logic [Channels-1:0] ChOne = Channels'(1);

  oclib_reset_seq_state_e state;
  logic [CntW-1:0]     cnt;
  logic [CntW-1:0]     cnt_inc_c;
  logic [IdxW-1:0]     idx;
  logic [Channels-1:0] ch;
  logic                done_q;
  logic                busy_q;
  logic                rst_sync;
  logic                req_c;

  oclib_reset_release_sync #(
    .Depth (SyncCycles)
  ) u_sync (
    .clock  (clock),
    .resetN (resetN),
    .synced (rst_sync)
  );

  assign req_c     = !rst_sync || softReset;
  assign cnt_inc_c = (cnt == '1) ? cnt : cnt + CntW'(1);

  // Sequencer FSM: hold for the minimum width, then release channels in order.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      ch     <= '1;
      done_q <= 1'b0;
      busy_q <= 1'b1;
    end else if (req_c) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      ch     <= '1;
      done_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (cnt >= CntW'(MinM1)) begin
            cnt <= '0;
            if (ReleaseGap == 0 || Channels == 1) begin
              ch     <= '0;
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              ch    <= ch & ~ChOne;
              idx   <= IdxW'(1);
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        RELEASE: begin
          if (cnt >= CntW'(GapM1)) begin
            cnt <= '0;
            ch  <= ch & ~(ChOne << idx);
            idx <= idx + IdxW'(1);
            if (idx == IdxW'(Channels - 1)) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        DONE: begin
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign busy = busy_q;

  if (ResetPipeline == 0) begin : g_nopipe
    assign out   = ch;
    assign ready = done_q;
  end else begin : g_pipe
    logic [Channels-1:0]      out_q [ResetPipeline];
    logic [ResetPipeline-1:0] rdy_q;

    // Fanout stages on out/ready; out stages set asynchronously with resetN.
    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        for (int i = 0; i < int'(ResetPipeline); i++) out_q[i] <= '1;
        rdy_q <= '0;
      end else begin
        out_q[0] <= ch;
        rdy_q[0] <= done_q;
        for (int i = 1; i < int'(ResetPipeline); i++) begin
          out_q[i] <= out_q[i-1];
          rdy_q[i] <= rdy_q[i-1];
        end
      end
    end

    assign out   = out_q[ResetPipeline-1];
    assign ready = rdy_q[ResetPipeline-1];
  end

endmodule
